// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: FSM state encoding, default widths
// and the one-bit right-shift-with-sticky step used by the aligner and normalizer.
package fp_pkg;

  localparam int unsigned EXP_WIDTH_DEF      = 8;
  localparam int unsigned MANTISSA_WIDTH_DEF = 23;
  localparam int unsigned MANT_W             = MANTISSA_WIDTH_DEF + 1;
  localparam int unsigned MAX_SHIFT          = MANTISSA_WIDTH_DEF + 2;

  // Wide enough for any {mantissa, guard, round} working register in the datapath.
  localparam int unsigned STEP_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [STEP_W-1:0] work;
    logic              sticky;
  } step_t;

  function automatic int unsigned count_width(input int unsigned max_shift);
    return $clog2(max_shift + 1);
  endfunction

  // Shift the LSB-aligned working register right by one; the bit leaving the round
  // position is folded into sticky.
  function automatic step_t shift_step(input logic [STEP_W-1:0] work, input logic sticky);
    step_t res;
    res.work   = work >> 1;
    res.sticky = sticky | work[0];
    return res;
  endfunction

endpackage

// File: rtl/denormalizer.sv
// Multi-cycle mantissa aligner: shifts a normalized mantissa right by
// (target - exponent), one bit per clock, producing guard/round/sticky bits.
module denormalizer
  import fp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH      = EXP_WIDTH_DEF,
  parameter int unsigned MANTISSA_WIDTH = MANTISSA_WIDTH_DEF
) (
  input  logic                      clock_in,
  input  logic                      reset_n_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [EXP_WIDTH-1:0]      expoent_in,
  input  logic [MANTISSA_WIDTH:0]   mantissa_in,
  input  logic [EXP_WIDTH-1:0]      target_e_in,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [EXP_WIDTH-1:0]      denorm_e_out,
  output logic [MANTISSA_WIDTH:0]   denorm_m_out,
  output logic                      guard_out,
  output logic                      round_out,
  output logic                      sticky_out,
  output logic                      error_out
);

  localparam int unsigned MW     = MANTISSA_WIDTH + 1;
  localparam int unsigned WORK_W = MW + 2;
  localparam int unsigned MAX_SH = MANTISSA_WIDTH + 2;
  localparam int unsigned CNT_W  = count_width(MAX_SH);
  localparam int unsigned DIFF_W = EXP_WIDTH + 1;

  state_t                state_q, state_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic                  sticky_q, sticky_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic                  error_q, error_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;

  logic [DIFF_W-1:0]     diff;
  step_t                 step;
  logic                  unused_step;

  assign diff        = DIFF_W'(target_e_in) - DIFF_W'(expoent_in);
  assign step        = shift_step(STEP_W'(work_q), sticky_q);
  assign unused_step = ^step.work[STEP_W-1:WORK_W];

  // Next-state and datapath load/shift decisions.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    exp_d    = exp_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          // MSB of the widened difference set means target < exponent, including wraps.
          if (diff[DIFF_W-1]) begin
            work_d   = {mantissa_in, 2'b00};
            sticky_d = 1'b0;
            exp_d    = expoent_in;
            error_d  = 1'b1;
            state_d  = DONE;
          end else if (diff == '0) begin
            work_d   = {mantissa_in, 2'b00};
            sticky_d = 1'b0;
            exp_d    = target_e_in;
            error_d  = 1'b0;
            state_d  = DONE;
          end else if (diff <= DIFF_W'(MAX_SH)) begin
            work_d   = {mantissa_in, 2'b00};
            sticky_d = 1'b0;
            count_d  = CNT_W'(diff);
            exp_d    = target_e_in;
            error_d  = 1'b0;
            state_d  = SHIFT;
          end else begin
            work_d   = '0;
            sticky_d = |mantissa_in;
            exp_d    = target_e_in;
            error_d  = 1'b0;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d   = step.work[WORK_W-1:0];
        sticky_d = step.sticky;
        count_d  = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (ready_in) begin
          error_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      work_q   <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      exp_q    <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_out    = ready_q;
  assign valid_out    = valid_q;
  assign denorm_e_out = exp_q;
  assign denorm_m_out = work_q[WORK_W-1:2];
  assign guard_out    = work_q[1];
  assign round_out    = work_q[0];
  assign sticky_out   = sticky_q;
  assign error_out    = error_q;

endmodule

// File: tb/tb_denormalizer.sv
// Self-checking bench for denormalizer: vector table with a scoreboard queue,
// plus hand sequences for output hold in DONE and reset during a shift.
module tb_denormalizer;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  t;
    logic [23:0] xm;
    logic [7:0]  xe;
    logic        xg, xr, xs, xerr;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [7:0]  expoent_in = '0;
  logic [23:0] mantissa_in = '0;
  logic [7:0]  target_e_in = '0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [7:0]  denorm_e_out;
  logic [23:0] denorm_m_out;
  logic        guard_out, round_out, sticky_out, error_out;

  int errors = 0;
  int checks = 0;
  vec_t sb[$];
  vec_t vecs[16];

  denormalizer #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clock_in     (clk),
    .reset_n_in   (reset_n),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .expoent_in   (expoent_in),
    .mantissa_in  (mantissa_in),
    .target_e_in  (target_e_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .denorm_e_out (denorm_e_out),
    .denorm_m_out (denorm_m_out),
    .guard_out    (guard_out),
    .round_out    (round_out),
    .sticky_out   (sticky_out),
    .error_out    (error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference alignment: one wide shift of the mantissa above 66 zero bits.
  function automatic vec_t model(input logic [7:0] e, input logic [23:0] m, input logic [7:0] t);
    vec_t v;
    logic [89:0] big;
    int d;
    v.e = e; v.m = m; v.t = t;
    v.xg = 1'b0; v.xr = 1'b0; v.xs = 1'b0; v.xerr = 1'b0;
    if (t < e) begin
      v.xm = m; v.xe = e; v.xerr = 1'b1; v.lat = 1;
    end else begin
      d = int'(t) - int'(e);
      v.xe = t;
      big = {m, 66'd0} >> d;
      v.xm = big[89:66];
      v.xg = big[65];
      v.xr = big[64];
      v.xs = |big[63:0];
      v.lat = (d == 0 || d >= 26) ? 1 : d + 1;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic [7:0] e, input logic [23:0] m, input logic [7:0] t,
                              input logic [23:0] xm, input logic [7:0] xe, input logic xg,
                              input logic xr, input logic xs, input logic xerr, input int lat);
    vec_t v;
    v.e = e; v.m = m; v.t = t; v.xm = xm; v.xe = xe;
    v.xg = xg; v.xr = xr; v.xs = xs; v.xerr = xerr; v.lat = lat;
    return v;
  endfunction

  task automatic start_op(input vec_t v);
    @(negedge clk);
    expoent_in  = v.e;
    mantissa_in = v.m;
    target_e_in = v.t;
    valid_in    = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_and_check(input int idx);
    int edges;
    vec_t x;
    edges = 1;
    while (!valid_out && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    x = sb.pop_front();
    if (!valid_out) begin
      check($sformatf("v%0d_timeout", idx), 32'(valid_out), 32'd1);
    end else begin
      check($sformatf("v%0d_latency", idx), 32'(edges), 32'(x.lat));
      check($sformatf("v%0d_m", idx), 32'(denorm_m_out), 32'(x.xm));
      check($sformatf("v%0d_e", idx), 32'(denorm_e_out), 32'(x.xe));
      check($sformatf("v%0d_grs", idx), 32'({guard_out, round_out, sticky_out}),
            32'({x.xg, x.xr, x.xs}));
      check($sformatf("v%0d_err", idx), 32'(error_out), 32'(x.xerr));
      check($sformatf("v%0d_ready_low", idx), 32'(ready_out), 32'd0);
    end
  endtask

  task automatic release_result(input int idx);
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check($sformatf("v%0d_release", idx), 32'({valid_out, ready_out, error_out}), 32'b010);
  endtask

  task automatic run_vec(input int idx);
    start_op(vecs[idx]);
    wait_and_check(idx);
    release_result(idx);
  endtask

  initial begin
    logic [7:0] re;
    logic       seen;
    vecs[0] = mk(8'd127, 24'h800000, 8'd128, 24'h400000, 8'd128, 0, 0, 0, 0, 2);
    vecs[1] = mk(8'd100, 24'hFFFFFF, 8'd103, 24'h1FFFFF, 8'd103, 1, 1, 1, 0, 4);
    vecs[2] = mk(8'd100, 24'hFFFFFF, 8'd102, 24'h3FFFFF, 8'd102, 1, 1, 0, 0, 3);
    vecs[3] = mk(8'd10,  24'h800001, 8'd40,  24'h000000, 8'd40,  0, 0, 1, 0, 1);
    vecs[4] = mk(8'd10,  24'h800001, 8'd10,  24'h800001, 8'd10,  0, 0, 0, 0, 1);
    vecs[5] = mk(8'd200, 24'hABCDEF, 8'd199, 24'hABCDEF, 8'd200, 0, 0, 0, 1, 1);
    vecs[6] = mk(8'd255, 24'h812345, 8'd0,   24'h812345, 8'd255, 0, 0, 0, 1, 1);
    vecs[7] = mk(8'd0,   24'h800000, 8'd25,  24'h000000, 8'd25,  0, 1, 0, 0, 26);
    vecs[8] = mk(8'd0,   24'h800000, 8'd26,  24'h000000, 8'd26,  0, 0, 1, 0, 1);
    vecs[9] = mk(8'd1,   24'hC00001, 8'd25,  24'h000000, 8'd25,  1, 1, 1, 0, 25);
    for (int i = 10; i < 16; i++) begin
      re = 8'($urandom_range(0, 200));
      vecs[i] = model(re, {1'b1, 23'($urandom)}, 8'(int'(re) + int'($urandom_range(0, 30))));
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready_out), 32'd1);
    check("reset_outs", 32'({valid_out, error_out, guard_out, round_out, sticky_out}), 32'd0);
    check("reset_data", 32'(denorm_m_out) | 32'(denorm_e_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Outputs hold in DONE while downstream stalls; new valid_in pulses are ignored.
    start_op(vecs[1]);
    wait_and_check(100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      expoent_in  = 8'd3;
      mantissa_in = 24'h123456;
      target_e_in = 8'd9;
      valid_in    = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      check($sformatf("hold%0d_vr", k), 32'({valid_out, ready_out}), 32'b10);
      check($sformatf("hold%0d_m", k), 32'(denorm_m_out), 32'h1FFFFF);
      check($sformatf("hold%0d_e_grs", k),
            32'({denorm_e_out, guard_out, round_out, sticky_out}), 32'({8'd103, 3'b111}));
    end
    release_result(100);

    // Reset in the third SHIFT cycle of a 10-bit shift discards the operation.
    start_op(mk(8'd50, 24'hFFFFFF, 8'd60, 24'h0, 8'd60, 0, 0, 0, 0, 11));
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready", 32'(ready_out), 32'd1);
    check("rst_mid_outs", 32'({valid_out, error_out, guard_out, round_out, sticky_out}), 32'd0);
    check("rst_mid_data", 32'(denorm_m_out) | 32'(denorm_e_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen = seen | valid_out;
    end
    check("rst_mid_no_valid", 32'({seen, ready_out}), 32'b01);
    run_vec(2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
